// File: rtl/ext_bus_slave_seq_if.sv
// Multiplexed 16-bit external bus pins: ARM master side, FPGA slave side.
// Strobes are active low and asynchronous to the fabric clock.
interface ext_bus_slave_seq_if;
  logic        ce_n;
  logic        we_n;
  logic        oe_n;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;

  modport master (
    output ce_n,
    output we_n,
    output oe_n,
    output bus_in,
    input  bus_out,
    input  bus_oe
  );

  modport slave (
    input  ce_n,
    input  we_n,
    input  oe_n,
    input  bus_in,
    output bus_out,
    output bus_oe
  );
endinterface

// File: rtl/ext_bus_slave_seq.sv
// External-bus to register-fabric sequencer (address/data multiplexed).
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module ext_bus_slave_seq #(
  parameter int          ADDR_W      = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] ID_WORD     = 16'hA501,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  ext_bus_slave_seq_if.slave bus,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              rd_stb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              err_flag
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_WAIT,
    DATA
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] ce_sync;
  logic [SYNC_STAGES-1:0] we_sync;
  logic [SYNC_STAGES-1:0] oe_sync;
  logic [15:0]            bus_sync [SYNC_STAGES];

  logic        s_ce;
  logic        s_we;
  logic        s_oe;
  logic [15:0] s_bus;
  logic        s_we_d;
  logic        s_oe_d;

  logic we_rise;
  logic oe_fall;
  logic oe_rise;
  logic edge_any;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] step;
  logic              autoinc;
  logic              rd_pend;
  logic [15:0]       out_q;
  logic              oe_q;
  logic              locked;

  // Strobe flops reset high so releasing reset never looks like an edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ce_sync <= '1;
      we_sync <= '1;
      oe_sync <= '1;
      s_we_d  <= 1'b1;
      s_oe_d  <= 1'b1;
      for (int i = 0; i < SYNC_STAGES; i++)
        bus_sync[i] <= '0;
    end else begin
      ce_sync <= {ce_sync[SYNC_STAGES-2:0], bus.ce_n};
      we_sync <= {we_sync[SYNC_STAGES-2:0], bus.we_n};
      oe_sync <= {oe_sync[SYNC_STAGES-2:0], bus.oe_n};
      s_we_d  <= s_we;
      s_oe_d  <= s_oe;
      bus_sync[0] <= bus.bus_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        bus_sync[i] <= bus_sync[i-1];
    end
  end

  assign s_ce  = ce_sync[SYNC_STAGES-1];
  assign s_we  = we_sync[SYNC_STAGES-1];
  assign s_oe  = oe_sync[SYNC_STAGES-1];
  assign s_bus = bus_sync[SYNC_STAGES-1];

  assign we_rise  = s_we & ~s_we_d;
  assign oe_fall  = ~s_oe & s_oe_d;
  assign oe_rise  = s_oe & ~s_oe_d;
  assign edge_any = we_rise | oe_fall | oe_rise;

  always_comb begin
    step = '0;
    if (autoinc)
      step = ADDR_W'(we_rise) + ADDR_W'(oe_rise);
  end

  assign bus.bus_out = out_q;
  assign bus.bus_oe  = oe_q;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = !s_ce && state != IDLE && !edge_any
                && tmo_cnt == CNT_W'(TIMEOUT_CYC);
`else
  assign locked = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= '0;
      autoinc  <= 1'b0;
      rd_pend  <= 1'b0;
      out_q    <= '0;
      oe_q     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_stb   <= 1'b0;
      rd_addr  <= '0;
      err_flag <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt  <= '0;
      locked   <= 1'b0;
`endif
    end else begin
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      rd_pend <= 1'b0;
      if (s_ce) begin
        state <= IDLE;
        oe_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (!locked)
              state <= ADDR_WAIT;
          end
          ADDR_WAIT: begin
            if (we_rise) begin
              addr    <= s_bus[ADDR_W-1:0];
              autoinc <= s_bus[15];
              state   <= DATA;
              oe_q    <= 1'b0;
              if (oe_q || oe_fall)
                err_flag <= 1'b1;
            end else if (oe_fall) begin
              if (s_we) begin
                out_q <= ID_WORD;
                oe_q  <= 1'b1;
              end else begin
                err_flag <= 1'b1;
              end
            end else if (oe_rise) begin
              oe_q <= 1'b0;
            end
          end
          DATA: begin
            addr <= addr + step;
            if (we_rise) begin
              wr_stb  <= 1'b1;
              wr_addr <= addr;
              wr_data <= s_bus;
              oe_q    <= 1'b0;
              if (oe_q || rd_pend || oe_fall)
                err_flag <= 1'b1;
            end else begin
              if (oe_fall) begin
                if (s_we) begin
                  rd_stb  <= 1'b1;
                  rd_addr <= addr;
                  rd_pend <= 1'b1;
                end else begin
                  err_flag <= 1'b1;
                end
              end
              // A read whose OE pulse already ended is abandoned
              if (rd_pend && !oe_rise && s_we) begin
                out_q <= rd_data;
                oe_q  <= 1'b1;
              end
              if (oe_rise)
                oe_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef BUS_TIMEOUT_EN
      if (state == IDLE || edge_any || s_ce)
        tmo_cnt <= '0;
      else if (tmo_cnt != CNT_W'(TIMEOUT_CYC))
        tmo_cnt <= tmo_cnt + 1'b1;
      if (s_ce)
        locked <= 1'b0;
      // Stuck session: drop the bus and wait for a fresh CE cycle
      if (tmo_hit) begin
        state    <= IDLE;
        oe_q     <= 1'b0;
        rd_pend  <= 1'b0;
        err_flag <= 1'b1;
        locked   <= 1'b1;
      end
`endif
    end
  end

endmodule
